entropy_src_cntr_bank: RTL

ENTROPY_SRC_CNTR_BANK -- requirements
Module: entropy_src_cntr_bank

---
 rtl/entropy_src_cntr_bank.sv | 99 +++++++++
 1 files changed

// File: rtl/entropy_src_cntr_bank.sv
// Bank of saturating event counters with complement shadows, registered max, sticky alert and sticky error.
// Counts are visible one cycle after the event and max_o one cycle later still; there is no backpressure.
module entropy_src_cntr_bank #(
  parameter int NumCntr  = 4,
  parameter int RegWidth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic [NumCntr-1:0]           clear_sel_i,
  input  logic [NumCntr-1:0]           event_i,
  input  logic [RegWidth-1:0]          thresh_i,
  output logic [NumCntr*RegWidth-1:0]  value_o,
  output logic [NumCntr-1:0]           sat_o,
  output logic [RegWidth-1:0]          max_o,
  output logic                         alert_o,
  output logic                         err_o
);

  localparam logic [RegWidth-1:0] One = RegWidth'(1);

  logic [RegWidth-1:0] cnt_q    [NumCntr];
  logic [RegWidth-1:0] cnt_d    [NumCntr];
  logic [RegWidth-1:0] shadow_q [NumCntr];
  logic [RegWidth-1:0] max_c;
  logic [RegWidth-1:0] max_q;
  logic                mismatch;
  logic                over_thresh;
  logic                alert_q;
  logic                err_q;

  always_comb begin
    for (int i = 0; i < NumCntr; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_i || clear_sel_i[i]) begin
        cnt_d[i] = '0;
      end else if (event_i[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + One;
      end
    end
  end

  // All compares look at the primaries only; a corrupted shadow never skews max or alert.
  always_comb begin
    max_c       = '0;
    mismatch    = 1'b0;
    over_thresh = 1'b0;
    for (int i = 0; i < NumCntr; i++) begin
      if (cnt_q[i] > max_c) max_c = cnt_q[i];
      if (cnt_q[i] != ~shadow_q[i]) mismatch = 1'b1;
      if ((thresh_i != '0) && (cnt_q[i] >= thresh_i)) over_thresh = 1'b1;
    end
  end

  always_comb begin
    value_o = '0;
    sat_o   = '0;
    for (int i = 0; i < NumCntr; i++) begin
      value_o[i*RegWidth +: RegWidth] = cnt_q[i];
      sat_o[i] = (cnt_q[i] == '1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCntr; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NumCntr; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= ~cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_q   <= '0;
      alert_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      max_q <= clear_i ? '0 : max_c;
      if (clear_i) begin
        alert_q <= 1'b0;
      end else if (over_thresh) begin
        alert_q <= 1'b1;
      end
      // Sticky until reset: a global clear must not hide an integrity fault.
      if (mismatch) err_q <= 1'b1;
    end
  end

  assign max_o   = max_q;
  assign alert_o = alert_q;
  assign err_o   = err_q;

endmodule
